addsub_digit_serial: RTL and testbench

- Parametrised sequential add/subtract unit: WIDTH-bit two's-complement operands, processed DIGIT bits per clock through a DIGIT-bit ripple slice.
- Successor to the fixed 4-bit combinational adder/subtractor. Trades latency for area and adds a start/done handshake plus status flags (carry, signed overflow, zero).
- Sits as a shared arithmetic resource behind a simple controller; the controller issues one operation at a time.

---
 rtl/addsub_digit_serial.sv | 158 +++++++++++++++
 tb/tb_addsub_digit_serial.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_digit_serial.sv
// addsub_digit_serial
//   Digit-serial two's-complement add/subtract unit. Operands of WIDTH bits
//   are processed DIGIT bits per clock through one DIGIT-bit ripple slice,
//   least-significant digit first. The carry between slices is held in a
//   register. For subtraction, b is inverted per slice and the carry is
//   seeded with 1.
//
//   Optional feature: define ADDSUB_SAT_EN to replace an overflowing result
//   with the signed saturation value (0111..1 or 1000..0). ovf still reports
//   1, cout is unchanged, and zero is evaluated on the saturated result.
//   Without the macro the result wraps modulo 2^WIDTH.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of DIGIT
//   DIGIT  bits processed per clock
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, accepted in IDLE or DONE
//   mode    0 = a+b, 1 = a-b (sampled with start)
//   a, b    operands (sampled with start)
//   busy    high while digits are being processed
//   done    one-cycle pulse; result/flags valid from this cycle
//   result  sum/difference, held until the next accepted start
//   cout    carry out of MSB (subtract: 1 = no borrow)
//   ovf     signed overflow
//   zero    result == 0
module addsub_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] a_q, b_q;
  logic                    mode_q;
  logic                    carry_q;
  logic [CW-1:0]           cnt_q;

  logic                    accept;
  logic                    last;
  logic [DIGIT-1:0]        a_dig, b_dig;
  logic [DIGIT:0]          slice_sum;
  logic [WIDTH-1:0]        res_nxt;
  logic                    ovf_nxt;

`ifdef ADDSUB_SAT_EN
  // Signed saturation value for an overflow whose operand sign is neg.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    sat_value = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and status outputs. DONE accepts a new start exactly like
  // IDLE so the controller can issue operations back to back.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slice datapath: one DIGIT-wide ripple add of the current digit
  always_comb begin
    last      = (cnt_q == CW'(N - 1));
    a_dig     = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig     = b_q[cnt_q*DIGIT +: DIGIT] ^ {DIGIT{mode_q}};
    slice_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    // Only meaningful on the final slice, where slice_sum[DIGIT-1] is the
    // result MSB.
    ovf_nxt   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ mode_q)) &&
                (slice_sum[DIGIT-1] != a_q[WIDTH-1]);
    res_nxt   = result;
    res_nxt[cnt_q*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
`ifdef ADDSUB_SAT_EN
    if (last && ovf_nxt) res_nxt = sat_value(a_q[WIDTH-1]);
`endif
  end

  // Operand latch, digit counter, carry and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      mode_q  <= mode;
      carry_q <= mode;  // +1 of the two's-complement negate for subtract
      cnt_q   <= '0;
    end else if (state == BUSY) begin
      result  <= res_nxt;
      carry_q <= slice_sum[DIGIT];
      if (last) begin
        cout <= slice_sum[DIGIT];
        ovf  <= ovf_nxt;
        zero <= (res_nxt == '0);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Testbench for addsub_digit_serial. Three instances share clock, reset and
// request inputs: 16/4 (main), 8/1 (bit-serial) and 8/8 (single slice). The
// 8-bit instances see the low byte of a and b.
// Latency is reported as the index of the edge at which a synchronous
// consumer first captures done=1, counting the accepting edge as edge 0
// (N+1 for N digits).
module tb_addsub_digit_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        busy16, done16, cout16, ovf16, zero16;
  logic [15:0] result16;
  logic        busy8s, done8s, cout8s, ovf8s, zero8s;
  logic [7:0]  result8s;
  logic        busy8p, done8p, cout8p, ovf8p, zero8p;
  logic [7:0]  result8p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_digit_serial #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy16), .done(done16), .result(result16), .cout(cout16),
    .ovf(ovf16), .zero(zero16)
  );

  addsub_digit_serial #(.WIDTH(8), .DIGIT(1)) u8s (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a[7:0]),
    .b(b[7:0]), .busy(busy8s), .done(done8s), .result(result8s),
    .cout(cout8s), .ovf(ovf8s), .zero(zero8s)
  );

  addsub_digit_serial #(.WIDTH(8), .DIGIT(8)) u8p (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a[7:0]),
    .b(b[7:0]), .busy(busy8p), .done(done8p), .result(result8p),
    .cout(cout8p), .ovf(ovf8p), .zero(zero8p)
  );

  // Present a request for one edge (edge 0), then scramble the inputs.
  task automatic launch(input logic m, input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    start = 1'b1; mode = m; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; a = ~av; b = 16'hA5A5;
  endtask

  // Called #1 after edge first_edge-1. Waits for done on the chosen instance
  // (0 = 16/4, 1 = 8/1, 2 = 8/8); lat = -1 if it never arrives.
  task automatic wait_done(input int which, input int first_edge,
                           output int lat, output int bc);
    logic d, bz;
    lat = -1;
    bc  = 0;
    for (int e = first_edge; e <= first_edge + 40; e++) begin
      case (which)
        0:       bz = busy16;
        1:       bz = busy8s;
        default: bz = busy8p;
      endcase
      if (bz) bc++;
      @(posedge clk); #1;
      case (which)
        0:       d = done16;
        1:       d = done8s;
        default: d = done8p;
      endcase
      if (d) begin
        lat = e + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if ({busy16, done16, cout16, ovf16, zero16, result16} !== 21'd0) begin
      bad++;
      $display("FAIL reset_held: got %h want 0", {busy16, done16, cout16, ovf16, zero16, result16});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy16, done16, cout16, ovf16, zero16, result16,
         busy8s, done8s, result8s, busy8p, done8p, result8p} !== 41'd0) begin
      bad++;
      $display("FAIL reset_idle: outputs not all zero after reset release");
    end
  endtask

  task automatic test_add();
    int lat, bc;
    launch(1'b0, 16'h0001, 16'h0002);
    wait_done(0, 1, lat, bc);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL add_latency: got %0d want 5", lat); end
    total++;
    if (bc !== 4) begin bad++; $display("FAIL add_busy_cycles: got %0d want 4", bc); end
    total++;
    if (result16 !== 16'h0003) begin bad++; $display("FAIL add_result: got %h want 0003", result16); end
    total++;
    if ({cout16, ovf16, zero16} !== 3'b000) begin
      bad++; $display("FAIL add_flags: got %b want 000", {cout16, ovf16, zero16});
    end
    @(posedge clk); #1;
    total++;
    if ({done16, busy16, result16} !== {2'b00, 16'h0003}) begin
      bad++; $display("FAIL add_done_pulse_hold: got %h want 00003", {done16, busy16, result16});
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    launch(1'b1, 16'h0005, 16'h0002);
    wait_done(0, 1, lat, bc);
    total++;
    if ({result16, cout16, ovf16, zero16} !== {16'h0003, 3'b100}) begin
      bad++; $display("FAIL sub_5_2: got %h/%b want 0003/100", result16, {cout16, ovf16, zero16});
    end
    launch(1'b1, 16'h0004, 16'h0006);
    wait_done(0, 1, lat, bc);
    total++;
    if ({result16, cout16, ovf16, zero16} !== {16'hFFFE, 3'b000}) begin
      bad++; $display("FAIL sub_4_6: got %h/%b want fffe/000", result16, {cout16, ovf16, zero16});
    end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL sub_latency: got %0d want 5", lat); end
  endtask

  task automatic test_wrap();
    int lat, bc;
    launch(1'b0, 16'hFFFF, 16'h0001);
    wait_done(0, 1, lat, bc);
    total++;
    if ({result16, cout16, ovf16, zero16} !== {16'h0000, 3'b101}) begin
      bad++; $display("FAIL wrap_ffff_1: got %h/%b want 0000/101", result16, {cout16, ovf16, zero16});
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    logic [15:0] exp_pos, exp_neg;
`ifdef ADDSUB_SAT_EN
    exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
    exp_pos = 16'h8000; exp_neg = 16'h7FFF;
`endif
    launch(1'b0, 16'h7FFF, 16'h0001);
    wait_done(0, 1, lat, bc);
    total++;
    if ({result16, cout16, ovf16, zero16} !== {exp_pos, 3'b010}) begin
      bad++; $display("FAIL ovf_pos: got %h/%b want %h/010", result16, {cout16, ovf16, zero16}, exp_pos);
    end
    launch(1'b1, 16'h8000, 16'h0001);
    wait_done(0, 1, lat, bc);
    total++;
    if ({result16, cout16, ovf16, zero16} !== {exp_neg, 3'b110}) begin
      bad++; $display("FAIL ovf_neg: got %h/%b want %h/110", result16, {cout16, ovf16, zero16}, exp_neg);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bc;
    launch(1'b0, 16'h1234, 16'h1111);
    @(posedge clk); #1;                       // after edge 1
    @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 16'hFFFF; b = 16'h0F0F;
    @(posedge clk); #1;                       // edge 2, request ignored
    start = 1'b0;
    total++;
    if (busy16 !== 1'b1) begin bad++; $display("FAIL ignore_still_busy: got %b want 1", busy16); end
    wait_done(0, 3, lat, bc);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL ignore_latency: got %0d want 5", lat); end
    total++;
    if ({result16, cout16, ovf16, zero16} !== {16'h2345, 3'b000}) begin
      bad++; $display("FAIL ignore_result: got %h/%b want 2345/000", result16, {cout16, ovf16, zero16});
    end
    @(posedge clk); #1;
    total++;
    if ({busy16, done16} !== 2'b00) begin
      bad++; $display("FAIL ignore_no_second_op: got %b want 00", {busy16, done16});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(1'b0, 16'h0010, 16'h0020);
    wait_done(0, 1, lat, bc);
    total++;
    if (result16 !== 16'h0030) begin bad++; $display("FAIL b2b_first: got %h want 0030", result16); end
    // Still inside the DONE cycle: request the next operation.
    start = 1'b1; mode = 1'b1; a = 16'h0100; b = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    total++;
    if ({busy16, done16} !== 2'b10) begin
      bad++; $display("FAIL b2b_accept: busy/done got %b want 10", {busy16, done16});
    end
    wait_done(0, 1, lat, bc);
    total++;
    if ({lat, result16, cout16} !== {32'd5, 16'h00FF, 1'b1}) begin
      bad++; $display("FAIL b2b_second: lat %0d result %h cout %b want 5 00ff 1", lat, result16, cout16);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    launch(1'b0, 16'h1234, 16'h0001);
    @(posedge clk); #1;
    #3 rst_n = 1'b0;                          // between clock edges
    #1;
    total++;
    if ({busy16, done16, cout16, ovf16, zero16, result16,
         busy8s, done8s, result8s, busy8p, done8p, result8p} !== 41'd0) begin
      bad++;
      $display("FAIL reset_async: got busy %b result %h want 0 0000", busy16, result16);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16 || done8s || done8p) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_abort: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_narrow();
    int lat, bc;
    logic [7:0] exp_pos, exp_neg;
`ifdef ADDSUB_SAT_EN
    exp_pos = 8'h7F; exp_neg = 8'h80;
`else
    exp_pos = 8'h80; exp_neg = 8'h7F;
`endif
    launch(1'b0, 16'h007F, 16'h0001);
    wait_done(2, 1, lat, bc);
    total++;
    if ({lat, bc} !== {32'd2, 32'd1}) begin
      bad++; $display("FAIL w8d8_latency: lat %0d busy %0d want 2 1", lat, bc);
    end
    total++;
    if ({result8p, cout8p, ovf8p, zero8p} !== {exp_pos, 3'b010}) begin
      bad++; $display("FAIL w8d8_ovf_pos: got %h/%b want %h/010", result8p, {cout8p, ovf8p, zero8p}, exp_pos);
    end
    wait_done(1, 2, lat, bc);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL w8d1_latency: got %0d want 9", lat); end
    total++;
    if ({result8s, cout8s, ovf8s, zero8s} !== {exp_pos, 3'b010}) begin
      bad++; $display("FAIL w8d1_ovf_pos: got %h/%b want %h/010", result8s, {cout8s, ovf8s, zero8s}, exp_pos);
    end
    repeat (2) @(posedge clk);
    launch(1'b1, 16'h0080, 16'h0001);
    wait_done(1, 1, lat, bc);
    total++;
    if ({result8s, cout8s, ovf8s, zero8s} !== {exp_neg, 3'b110}) begin
      bad++; $display("FAIL w8d1_ovf_neg: got %h/%b want %h/110", result8s, {cout8s, ovf8s, zero8s}, exp_neg);
    end
    total++;
    if ({result8p, cout8p, ovf8p, zero8p} !== {exp_neg, 3'b110}) begin
      bad++; $display("FAIL w8d8_ovf_neg: got %h/%b want %h/110", result8p, {cout8p, ovf8p, zero8p}, exp_neg);
    end
    repeat (2) @(posedge clk);
    launch(1'b1, 16'h0005, 16'h0007);
    wait_done(1, 1, lat, bc);
    total++;
    if ({result8s, cout8s, ovf8s, zero8s} !== {8'hFE, 3'b000}) begin
      bad++; $display("FAIL w8d1_sub: got %h/%b want fe/000", result8s, {cout8s, ovf8s, zero8s});
    end
    repeat (2) @(posedge clk);
    launch(1'b0, 16'h00FF, 16'h0001);
    wait_done(1, 1, lat, bc);
    total++;
    if ({result8p, cout8p, ovf8p, zero8p, result8s, cout8s, zero8s} !== {8'h00, 3'b101, 8'h00, 2'b11}) begin
      bad++; $display("FAIL w8_wrap: got %h/%b %h/%b want 00/101 00/11",
                      result8p, {cout8p, ovf8p, zero8p}, result8s, {cout8s, zero8s});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
